// File: rtl/pll_pkg.sv
// Purpose: shared mode enum and elaboration-time helpers for the pll clock synthesiser.
// Latency: n/a (constant functions only, evaluated at elaboration).
// Backpressure: n/a.
package pll_pkg;

    typedef enum logic {
        PLL_MODE_DIV,
        PLL_MODE_NCO
    } pll_mode_e;

    // Integer ratio -> exact counter divider; anything else needs the NCO.
    // A zero fclk_hz is reported as DIV so the caller's range check fires
    // instead of a divide-by-zero here.
    function automatic pll_mode_e pll_mode(input longint unsigned clk_hz,
                                           input longint unsigned fclk_hz);
        if (fclk_hz == 0)
            return PLL_MODE_DIV;
        return ((clk_hz % fclk_hz) == 0) ? PLL_MODE_DIV : PLL_MODE_NCO;
    endfunction

    // Phase increment round(fclk_hz * 2**acc_w / clk_hz), in 64-bit arithmetic.
    function automatic longint unsigned pll_inc(input longint unsigned clk_hz,
                                                input longint unsigned fclk_hz,
                                                input int              acc_w);
        if (clk_hz == 0)
            return 0;
        return ((fclk_hz << acc_w) + (clk_hz >> 1)) / clk_hz;
    endfunction

endpackage

// File: rtl/pll_lock_detect.sv
// Purpose: counts rising edges of the synthesised clock and raises a sticky lock flag.
// Latency: locked rises on the clk edge that samples the LOCK_CYCLES-th fclk rise.
// Backpressure: none; free-running, cleared only by reset.
//
// Ports:
//   clk      in  reference clock, all state on its rising edge
//   reset    in  synchronous active-high reset
//   fclk_in  in  registered synthesised clock, sampled as data
//   locked   out 1 once LOCK_CYCLES rises have been seen since reset
module pll_lock_detect #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic fclk_in,
    output logic locked
);
    import pll_pkg::*;

    localparam int CW = $clog2(LOCK_CYCLES + 1);

    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("pll_lock_detect: LOCK_CYCLES must be at least 1");
    end

    logic          fclk_prev;
    logic [CW-1:0] rise_cnt;
    logic          rise;

    // fclk_in is already a flop output in the clk domain, so a single
    // history bit gives a clean edge detect.
    assign rise = fclk_in & ~fclk_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            fclk_prev <= 1'b0;
            rise_cnt  <= '0;
            locked    <= 1'b0;
        end else begin
            fclk_prev <= fclk_in;
            // Saturate so the counter cannot wrap back below the threshold.
            if (rise && (rise_cnt != CW'(LOCK_CYCLES)))
                rise_cnt <= rise_cnt + CW'(1);
            // Set on the same edge the count reaches the threshold.
            if (rise && (rise_cnt == CW'(LOCK_CYCLES - 1)))
                locked <= 1'b1;
        end
    end

endmodule

// File: rtl/pll.sv
// Purpose: fully digital clock synthesiser deriving fclk from clk (counter divider or NCO).
// Latency: fclk is registered; first divider rise on the DIV-th edge after reset release.
// Backpressure: none; free-running output, locked gates downstream start-up.
//
// Ports:
//   clk     in  reference clock, all state on its rising edge
//   reset   in  synchronous active-high reset
//   fclk    out synthesised clock, straight from a flop (glitch-free)
//   locked  out 1 once fclk has produced LOCK_CYCLES rising edges since reset
module pll #(
    parameter int unsigned CLK_HZ      = 200_000_000,
    parameter int unsigned FCLK_HZ     = 100_000_000,
    parameter int          ACC_W       = 32,
    parameter int          LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    output logic fclk,
    output logic locked
);
    import pll_pkg::*;

    localparam pll_mode_e MODE = pll_mode(64'(CLK_HZ), 64'(FCLK_HZ));

    if ((FCLK_HZ == 0) || ((64'(FCLK_HZ) * 2) > 64'(CLK_HZ))) begin : g_bad_ratio
        $error("pll: FCLK_HZ must be nonzero and at most CLK_HZ/2");
    end

    if ((ACC_W < 2) || (ACC_W > 62)) begin : g_bad_acc_w
        $error("pll: ACC_W out of range 2..62");
    end

    logic fclk_q;

    if (MODE == PLL_MODE_DIV) begin : g_div
        localparam int unsigned DIV   = (FCLK_HZ == 0) ? 2 : (CLK_HZ / FCLK_HZ);
        localparam int unsigned HI    = DIV / 2;
        localparam int          CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_n;
        logic             lap_done;

        always_comb begin
            cnt_n = (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + CNT_W'(1);
        end

        // The high phase is masked until the counter first wraps, so the
        // first rise lands on the DIV-th edge and every later period is
        // exactly DIV clk with HI high and DIV-HI low.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt      <= '0;
                lap_done <= 1'b0;
                fclk_q   <= 1'b0;
            end else begin
                cnt <= cnt_n;
                if (cnt_n == '0)
                    lap_done <= 1'b1;
                fclk_q <= (cnt_n < CNT_W'(HI)) && (lap_done || (cnt_n == '0));
            end
        end
    end else begin : g_nco
        localparam longint unsigned INC64 = pll_inc(64'(CLK_HZ), 64'(FCLK_HZ), ACC_W);
        localparam logic [ACC_W-1:0] INC  = INC64[ACC_W-1:0];

        if (INC64 == 0) begin : g_bad_inc
            $error("pll: NCO increment rounds to zero, widen ACC_W");
        end

        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] acc_n;

        // Wrap modulo 2**ACC_W is the phase wrap of the oscillator.
        always_comb begin
            acc_n = acc + INC;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                acc    <= '0;
                fclk_q <= 1'b0;
            end else begin
                acc    <= acc_n;
                fclk_q <= acc_n[ACC_W-1];
            end
        end
    end

    assign fclk = fclk_q;

    pll_lock_detect #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_detect (
        .clk     (clk),
        .reset   (reset),
        .fclk_in (fclk_q),
        .locked  (locked)
    );

endmodule

// File: tb/tb_pll.sv
// Bench for pll: four instances (DIV=2, DIV=4, DIV=5, NCO 100M/30M) share clk and reset.
// A closed-form reference model predicts fclk/locked after every edge.
// Table vectors cover start-up; hand sequences cover lock timing, ratios and mid-run reset.
module tb_pll;

    localparam longint unsigned NCO_INC = 64'd1288490189; // round(0.3 * 2**32)
    localparam int              LOCK_N  = 16;

    logic       clk;
    logic       reset;
    logic [3:0] fclk_v;
    logic [3:0] locked_v;

    int n_checks;
    int n_fail;

    // reference model state: edges since reset release, rises seen, last fclk
    int mk;
    int m_rises [4];
    bit m_prev  [4];
    bit m_f     [4];
    bit m_lock  [4];

    typedef struct {
        bit         rst;
        logic [3:0] f;   // {nco, div5, div4, div2}
        logic [3:0] l;
    } vec_t;
    vec_t vec [12];

    logic s5 [0:100];

    pll #(.CLK_HZ(200_000_000), .FCLK_HZ(100_000_000), .ACC_W(32), .LOCK_CYCLES(LOCK_N))
        u_div2 (.clk(clk), .reset(reset), .fclk(fclk_v[0]), .locked(locked_v[0]));
    pll #(.CLK_HZ(40_000_000), .FCLK_HZ(10_000_000), .ACC_W(32), .LOCK_CYCLES(LOCK_N))
        u_div4 (.clk(clk), .reset(reset), .fclk(fclk_v[1]), .locked(locked_v[1]));
    pll #(.CLK_HZ(50_000_000), .FCLK_HZ(10_000_000), .ACC_W(32), .LOCK_CYCLES(LOCK_N))
        u_div5 (.clk(clk), .reset(reset), .fclk(fclk_v[2]), .locked(locked_v[2]));
    pll #(.CLK_HZ(100_000_000), .FCLK_HZ(30_000_000), .ACC_W(32), .LOCK_CYCLES(LOCK_N))
        u_nco  (.clk(clk), .reset(reset), .fclk(fclk_v[3]), .locked(locked_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected fclk k edges after reset release.
    // Divider: low until the DIV-th edge, then high for the first DIV/2 of each period.
    // NCO: MSB of the phase k*INC mod 2**32.
    function automatic bit exp_fclk(input int idx, input int k);
        int d;
        longint unsigned ph;
        if (idx == 3) begin
            ph = longint'(k) * NCO_INC;
            return ph[31];
        end
        d = (idx == 0) ? 2 : (idx == 1) ? 4 : 5;
        return (k >= d) && ((k % d) < (d / 2));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d after reset)", name, act, exp, mk);
        end
    endtask

    // Drive reset, take one clk edge, update the model, sample on the falling edge.
    task automatic step(input bit r, input bit chk);
        reset = r;
        @(posedge clk);
        @(negedge clk);
        if (r) begin
            mk = 0;
            for (int i = 0; i < 4; i++) begin
                m_rises[i] = 0;
                m_prev[i]  = 1'b0;
                m_f[i]     = 1'b0;
                m_lock[i]  = 1'b0;
            end
        end else begin
            mk++;
            for (int i = 0; i < 4; i++) begin
                // rises visible on earlier edges decide lock on this edge
                m_lock[i] = m_lock[i] || (m_rises[i] >= LOCK_N);
                m_f[i]    = exp_fclk(i, mk);
                if (!m_prev[i] && m_f[i])
                    m_rises[i]++;
                m_prev[i] = m_f[i];
            end
        end
        if (chk) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model_fclk[%0d]", i), 32'(fclk_v[i]), 32'(m_f[i]));
                check($sformatf("model_locked[%0d]", i), 32'(locked_v[i]), 32'(m_lock[i]));
            end
        end
    endtask

    initial begin
        int rises;
        int bad;
        int st;
        int r0;
        int runlen;
        int maxrun;
        int hold;
        logic pv;
        logic v;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        mk       = 0;

        // start-up vectors, hand-derived edge by edge
        vec[0]  = '{1'b1, 4'b0000, 4'b0000};
        vec[1]  = '{1'b0, 4'b0000, 4'b0000};
        vec[2]  = '{1'b0, 4'b1001, 4'b0000};
        vec[3]  = '{1'b0, 4'b1000, 4'b0000};
        vec[4]  = '{1'b0, 4'b0011, 4'b0000};
        vec[5]  = '{1'b0, 4'b1110, 4'b0000};
        vec[6]  = '{1'b0, 4'b1101, 4'b0000};
        vec[7]  = '{1'b0, 4'b0000, 4'b0000};
        vec[8]  = '{1'b0, 4'b0011, 4'b0000};
        vec[9]  = '{1'b0, 4'b1010, 4'b0000};
        vec[10] = '{1'b0, 4'b0101, 4'b0000};
        vec[11] = '{1'b0, 4'b0100, 4'b0000};

        for (int i = 0; i < 12; i++) begin
            step(vec[i].rst, 1'b1);
            check($sformatf("vec%0d_fclk", i), 32'(fclk_v), 32'(vec[i].f));
            check($sformatf("vec%0d_locked", i), 32'(locked_v), 32'(vec[i].l));
        end

        // DIV=2: 16th rise on edge 32, seen by the lock detector on edge 33
        while (mk < 32) step(1'b0, 1'b1);
        check("div2_unlocked_edge32", 32'(locked_v[0]), 32'd0);
        step(1'b0, 1'b1);
        check("div2_locked_edge33", 32'(locked_v[0]), 32'd1);

        // DIV=5 over 100 clk: 20 rises, high 2 / low 3
        step(1'b1, 1'b1);
        s5[0] = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            step(1'b0, 1'b1);
            s5[j] = fclk_v[2];
        end
        rises = 0;
        r0    = -1;
        for (int j = 1; j <= 100; j++) begin
            if (s5[j-1] === 1'b0 && s5[j] === 1'b1) begin
                rises++;
                if (r0 < 0) r0 = j;
            end
        end
        bad = 0;
        if (r0 > 0) begin
            st = r0;
            for (int j = r0 + 1; j <= 100; j++) begin
                if (s5[j] !== s5[st]) begin
                    if ((s5[st] === 1'b1 && (j - st) != 2) || (s5[st] !== 1'b1 && (j - st) != 3))
                        bad++;
                    st = j;
                end
            end
        end
        check("div5_rises_100clk", 32'(rises), 32'd20);
        check("div5_bad_run_lengths", 32'(bad), 32'd0);

        // NCO over 10000 clk: 3000 +/- 1 rises, no level held longer than 2 clk
        step(1'b1, 1'b1);
        pv     = 1'b0;
        runlen = 1;
        maxrun = 0;
        rises  = 0;
        for (int j = 1; j <= 10000; j++) begin
            step(1'b0, 1'b1);
            v = fclk_v[3];
            if (v === pv) begin
                runlen++;
            end else begin
                if (runlen > maxrun) maxrun = runlen;
                runlen = 1;
            end
            if (pv === 1'b0 && v === 1'b1)
                rises++;
            pv = v;
        end
        if (runlen > maxrun) maxrun = runlen;
        n_checks++;
        if (rises < 2999 || rises > 3001) begin
            n_fail++;
            $display("FAIL nco_rises_10000clk: got %0d expected 3000 +/- 1", rises);
        end
        n_checks++;
        if (maxrun > 2) begin
            n_fail++;
            $display("FAIL nco_max_run: got %0d expected at most 2", maxrun);
        end

        // one-cycle reset while locked, then relock
        check("all_locked_before_reset", 32'(locked_v), 32'hF);
        step(1'b1, 1'b1);
        check("reset_mid_run_fclk", 32'(fclk_v), 32'h0);
        check("reset_mid_run_locked", 32'(locked_v), 32'h0);
        while (mk < 32) step(1'b0, 1'b1);
        check("relock_div2_edge32", 32'(locked_v[0]), 32'd0);
        step(1'b0, 1'b1);
        check("relock_div2_edge33", 32'(locked_v[0]), 32'd1);

        // random reset pulses of 1..3 clk over a long run, checked against the model
        for (int j = 0; j < 4000; j++) begin
            if ($urandom_range(0, 299) == 0) begin
                hold = $urandom_range(1, 3);
                for (int h = 0; h < hold; h++)
                    step(1'b1, 1'b1);
            end else begin
                step(1'b0, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
